// File: rtl/mux_nto1_pipe.sv
// N-to-1 selector with registered output, valid/ready flow control and a sticky out-of-range flag.
// Optional feature macro: MUX_PIPE_SKID_EN adds a skid register and makes ready_o a register output.
module mux_nto1_pipe #(
  parameter int SIZE   = 32,
  parameter int NUM_IN = 3,
  parameter int SEL_W  = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_IN*SIZE-1:0] data_i,
  input  logic [SEL_W-1:0]       select_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [SIZE-1:0]        data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   err_o
);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

  state_t          state_q, state_d;
  logic [SIZE-1:0] out_q, out_d;
  logic            err_q, err_d;
  logic [SIZE-1:0] sel_data;
  logic            in_range;
  logic            accept;
  logic            xfer;

`ifdef MUX_PIPE_SKID_EN
  logic [SIZE-1:0] skid_q, skid_d;
  logic            ready_q, ready_d;
`endif

  // Out-of-range selects fall through to the last populated input.
  always_comb begin
    sel_data = data_i[(NUM_IN-1)*SIZE +: SIZE];
    for (int k = 0; k < NUM_IN-1; k++) begin
      if ({1'b0, select_i} == (SEL_W+1)'(k)) sel_data = data_i[k*SIZE +: SIZE];
    end
  end

  assign in_range = ({1'b0, select_i} < NUM_IN_W);
  assign valid_o  = (state_q != ST_EMPTY);
  assign data_o   = out_q;
  assign err_o    = err_q;
  assign accept   = valid_i && ready_o;
  assign xfer     = valid_o && ready_i;

`ifdef MUX_PIPE_SKID_EN
  assign ready_o = ready_q;
`else
  assign ready_o = !valid_o || ready_i;
`endif

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    err_d   = err_q | (accept & ~in_range);
`ifdef MUX_PIPE_SKID_EN
    skid_d  = skid_q;
`endif
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d = ST_ONE;
          out_d   = sel_data;
        end
      end
      ST_ONE: begin
        if (accept && xfer) begin
          out_d = sel_data;
`ifdef MUX_PIPE_SKID_EN
        end else if (accept) begin
          state_d = ST_TWO;
          skid_d  = sel_data;
`endif
        end else if (xfer) begin
          state_d = ST_EMPTY;
        end
      end
`ifdef MUX_PIPE_SKID_EN
      ST_TWO: begin
        if (xfer) begin
          state_d = ST_ONE;
          out_d   = skid_q;
        end
      end
`endif
      default: state_d = ST_EMPTY;
    endcase
`ifdef MUX_PIPE_SKID_EN
    ready_d = (state_d != ST_TWO);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      err_q   <= 1'b0;
`ifdef MUX_PIPE_SKID_EN
      skid_q  <= '0;
      ready_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      err_q   <= err_d;
`ifdef MUX_PIPE_SKID_EN
      skid_q  <= skid_d;
      ready_q <= ready_d;
`endif
    end
  end

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Directed self-checking bench for mux_nto1_pipe; expectations follow the MUX_PIPE_SKID_EN build setting.
module tb_mux_nto1_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [95:0] data_i;
  logic [1:0]  select_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i;
  logic        err_o;

  int checks_total  = 0;
  int checks_passed = 0;

  mux_nto1_pipe #(.SIZE(32), .NUM_IN(3), .SEL_W(2)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .data_i   (data_i),
    .select_i (select_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_o   (data_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .err_o    (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks_total++;
    if (observed === expected) checks_passed++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Drives one cycle; acc reports whether the beat was taken at the edge.
  task automatic applyStimulus(input logic rst, input logic v, input logic [1:0] sel,
                               input logic [95:0] data, input logic rdy, output logic acc);
    rst_i    = rst;
    valid_i  = v;
    select_i = sel;
    data_i   = data;
    ready_i  = rdy;
    @(negedge clk_i);
    acc = valid_i && ready_o && !rst_i;
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [95:0] pack3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return {c, b, a};
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    logic        acc;
    logic [95:0] sweep;
    logic [31:0] words [3];
    logic [31:0] bp_beats [3];
    logic [31:0] bp_exp_data [7];
    logic        bp_exp_valid [7];
    logic        bp_exp_ready [7];
    logic        bp_exp_acc [7];
    logic        bp_rdy [7];
    int          idx;
    logic [31:0] beat;

    words[0] = 32'h11111111;
    words[1] = 32'h22222222;
    words[2] = 32'h33333333;
    sweep = pack3(words[0], words[1], words[2]);

    // Reset held two cycles with a valid beat on the inputs.
    applyStimulus(1'b1, 1'b1, 2'd1, sweep, 1'b1, acc);
    applyStimulus(1'b1, 1'b1, 2'd1, sweep, 1'b1, acc);
    checkOutput("reset_valid", {31'd0, valid_o}, 32'd0);
    checkOutput("reset_data", data_o, 32'd0);
    checkOutput("reset_err", {31'd0, err_o}, 32'd0);
    checkOutput("reset_ready", {31'd0, ready_o}, 32'd1);
    applyStimulus(1'b0, 1'b0, 2'd0, sweep, 1'b1, acc);
    checkOutput("post_reset_valid", {31'd0, valid_o}, 32'd0);
    checkOutput("post_reset_data", data_o, 32'd0);

    // Select sweep.
    for (int s = 0; s < 3; s++) begin
      applyStimulus(1'b0, 1'b1, 2'(s), sweep, 1'b1, acc);
      checkOutput($sformatf("sweep_data_%0d", s), data_o, words[s]);
      checkOutput($sformatf("sweep_valid_%0d", s), {31'd0, valid_o}, 32'd1);
      checkOutput($sformatf("sweep_err_%0d", s), {31'd0, err_o}, 32'd0);
    end

    // Out-of-range select, then the flag must stick through legal beats.
    applyStimulus(1'b0, 1'b1, 2'd3, sweep, 1'b1, acc);
    checkOutput("oor_data", data_o, 32'h33333333);
    checkOutput("oor_err", {31'd0, err_o}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 1'b1, 2'(k % 3), sweep, 1'b1, acc);
      checkOutput($sformatf("sticky_data_%0d", k), data_o, words[k % 3]);
      checkOutput($sformatf("sticky_err_%0d", k), {31'd0, err_o}, 32'd1);
    end
    applyStimulus(1'b0, 1'b0, 2'd0, sweep, 1'b1, acc);
    checkOutput("idle_valid", {31'd0, valid_o}, 32'd0);
    checkOutput("idle_data_hold", data_o, 32'h11111111);

    applyStimulus(1'b1, 1'b0, 2'd0, sweep, 1'b1, acc);
    checkOutput("reset_clears_err", {31'd0, err_o}, 32'd0);

    // Backpressure: beats A, B, C offered in order, each held until taken.
    bp_beats[0] = 32'hAAAA0001;
    bp_beats[1] = 32'hBBBB0002;
    bp_beats[2] = 32'hCCCC0003;
    bp_rdy = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bp_exp_data  = '{bp_beats[0], bp_beats[0], bp_beats[0], bp_beats[0], bp_beats[1], bp_beats[2], bp_beats[2]};
    bp_exp_valid = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`ifdef MUX_PIPE_SKID_EN
    bp_exp_ready = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bp_exp_acc   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`else
    bp_exp_ready = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bp_exp_acc   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
`endif
    idx = 0;
    for (int c = 0; c < 7; c++) begin
      beat = (idx < 3) ? bp_beats[idx] : 32'h0;
      applyStimulus(1'b0, idx < 3, 2'd0, pack3(beat, 32'h0, 32'h0), bp_rdy[c], acc);
      if (acc) idx++;
      checkOutput($sformatf("bp_acc_%0d", c), {31'd0, acc}, {31'd0, bp_exp_acc[c]});
      checkOutput($sformatf("bp_data_%0d", c), data_o, bp_exp_data[c]);
      checkOutput($sformatf("bp_valid_%0d", c), {31'd0, valid_o}, {31'd0, bp_exp_valid[c]});
      checkOutput($sformatf("bp_ready_%0d", c), {31'd0, ready_o}, {31'd0, bp_exp_ready[c]});
    end

    // Back-to-back accept and transfer for 8 beats.
    for (int k = 0; k < 8; k++) begin
      beat = 32'h10000000 + 32'(k);
      case (k % 3)
        0:       sweep = pack3(beat, 32'h0, 32'h0);
        1:       sweep = pack3(32'h0, beat, 32'h0);
        default: sweep = pack3(32'h0, 32'h0, beat);
      endcase
      applyStimulus(1'b0, 1'b1, 2'(k % 3), sweep, 1'b1, acc);
      checkOutput($sformatf("stream_data_%0d", k), data_o, beat);
      checkOutput($sformatf("stream_valid_%0d", k), {31'd0, valid_o}, 32'd1);
    end
    applyStimulus(1'b0, 1'b0, 2'd0, sweep, 1'b1, acc);
    checkOutput("stream_drain_valid", {31'd0, valid_o}, 32'd0);

    // Reset while stalled: held beats must be discarded.
    applyStimulus(1'b0, 1'b1, 2'd1, pack3(32'h0, 32'h50505050, 32'h0), 1'b0, acc);
    applyStimulus(1'b0, 1'b1, 2'd1, pack3(32'h0, 32'h60606060, 32'h0), 1'b0, acc);
    checkOutput("stall_data", data_o, 32'h50505050);
    applyStimulus(1'b1, 1'b1, 2'd1, pack3(32'h0, 32'h70707070, 32'h0), 1'b0, acc);
    checkOutput("midreset_valid", {31'd0, valid_o}, 32'd0);
    checkOutput("midreset_ready", {31'd0, ready_o}, 32'd1);
    checkOutput("midreset_data", data_o, 32'd0);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b0, 2'd0, '0, 1'b1, acc);
      checkOutput($sformatf("after_reset_valid_%0d", k), {31'd0, valid_o}, 32'd0);
      checkOutput($sformatf("after_reset_data_%0d", k), data_o, 32'd0);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/mux_nto1_pipe.md
# mux_nto1_pipe

Parametrised N-to-1 selector with a registered output stage and valid/ready flow control. It replaces the plain combinational 3-way selector in the pipelined datapath wherever the selected value must cross a stage boundary, such as forwarding into the EX stage register or write-back source selection. It also reports selects that fall outside the populated inputs.

## Interface
- SIZE, 32, data width per input in bits
- NUM_IN, 3, number of populated inputs (2..2^SEL_W)
- SEL_W, 2, select width in bits
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  reset; synchronous and active-high
- data_i  input  NUM_IN*SIZE  packed inputs; input k occupies bits [k*SIZE +: SIZE]
- select_i  input  SEL_W  input index, sampled on accept
- valid_i  input  1  upstream beat valid
- ready_o  output  1  block can accept a beat this cycle
- data_o  output  SIZE  selected data, registered
- valid_o  output  1  data_o holds a beat
- ready_i  input  1  downstream accepts data_o this cycle
- err_o  output  1  sticky flag: an out-of-range select was accepted

## Operation
- Accept: valid_i && ready_o at a rising edge. Transfer out: valid_o && ready_i at a rising edge.
- Selection is evaluated at accept:
  - select_i < NUM_IN: takes input select_i.
  - select_i >= NUM_IN: takes input NUM_IN-1, which preserves the legacy "else" behaviour, and sets err_o.
- err_o stays set until rst_i. It is set in the cycle after the offending accept.
- Storage is an output register (OUT) plus an optional skid register (SKID). See Configuration.
- States with skid:
  - EMPTY (OUT and SKID empty)
  - ONE (OUT full)
  - TWO (OUT and SKID full)
- Transitions with skid:
  - EMPTY: on accept, go to ONE and load OUT.
  - ONE, accept only: go to TWO and load SKID.
  - ONE, transfer and accept together: stay in ONE and reload OUT with the new beat.
  - ONE, transfer only: go to EMPTY.
  - TWO, transfer: go to ONE with OUT <= SKID. ready_o is 0 in TWO, so no accept is possible.
- Order is strictly FIFO. No beat is dropped or duplicated.
- Registered contents do not change while valid_o && !ready_i. data_o must stay stable.
- When valid_o is 0, data_o holds its last value. It is not cleared.

## Timing
- Reset values: valid_o=0, data_o=0, err_o=0, ready_o=1. The skid is empty.
- Latency: a beat accepted at edge n appears on data_o/valid_o after edge n (one cycle).
- Throughput: one beat per cycle while ready_i=1.
- With skid:
  - ready_o is a register output, equal to (state != TWO).
  - It falls the cycle after SKID fills.
  - It rises the cycle after a transfer out of TWO.
- Without skid: ready_o = !valid_o || ready_i (combinational).
- Reset asserted mid-stream discards OUT and SKID and clears err_o. Beats presented during the reset cycle are not accepted.
- select_i and data_i matter only in the accepting cycle.

## Configuration
- MUX_PIPE_SKID_EN defined:
  - SKID register present.
  - ready_o registered, with no combinational path from ready_i.
  - Full throughput under backpressure.
- Not defined:
  - OUT only.
  - ready_o combinationally depends on ready_i.
  - State machine reduces to EMPTY/ONE.
  - All other behaviour is identical.

## Test plan
- Reset: assert rst_i for 2 cycles while valid_i=1 -> valid_o=0, data_o=0, err_o=0, ready_o=1. No beat is accepted.
- Select sweep (SIZE=32, NUM_IN=3):
  - Inputs are 0x11111111, 0x22222222, 0x33333333.
  - Drive select 0, 1, 2 in consecutive cycles with ready_i=1.
  - Expect data_o = 0x11111111, 0x22222222, 0x33333333 on the three cycles after each accept.
- Out-of-range: select_i=3 accepted -> data_o=0x33333333 next cycle. err_o=1 from that cycle and it stays 1 across 10 further legal beats.
- Backpressure (skid on):
  - Stream beats A, B, C with ready_i=0.
  - Expect A held on data_o, B in SKID, ready_o=0 from the cycle after B is accepted, and C not accepted.
  - Raise ready_i -> A, B, C emerge in order with no gaps once C is accepted.
- Simultaneous accept and transfer in ONE with ready_i=1 for 8 cycles -> 8 beats out in order, valid_o continuously 1. Repeat with the macro undefined -> identical output sequence.
- Reset mid-backpressure: in state TWO assert rst_i -> next cycle valid_o=0, ready_o=1. The old beats never appear.
